seq_sub_32_bits: RTL
====================

Name: seq_sub_32_bits

Overview:
- Multi-cycle 32-bit subtractor with borrow-in; the subtract counterpart to the team's adder family.
- Computes a - b - b_in one SLICE-bit slice per clock, least-significant slice first, chaining the borrow between slices.
- Reports the difference, borrow-out, signed overflow and zero flags through a start/ready/done handshake.
- Sits in the ALU datapath wherever a subtract may take several cycles in exchange for a narrow slice subtractor.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE (default 4).

Ports:
- clk  input  1  system clock; everything is registered on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  request; accepted only while ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- b_in  input  1  borrow in; sampled on the accepting edge.
- ready  output  1  1 only in IDLE.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result.
- b_out  output  1  final borrow; 1 iff unsigned a < b + b_in.
- ovf  output  1  two's-complement overflow.
- zero  output  1  1 iff diff == 0.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, done=0, diff=0, b_out=0, ovf=0, zero=0. Slice index, working borrow and working registers are cleared.
- Reset during RUN or DONE aborts the operation. No done pulse is produced, and outputs go to their reset values.
- States:
  - IDLE: ready=1. An edge with start=1 latches a, b and b_in into working registers, sets borrow=b_in and idx=0, and moves to RUN.
  - RUN: ready=0. Each edge computes {bo, d} = a[idx slice] - b[idx slice] - borrow, with the result SLICE+1 bits wide and bo=1 on underflow. It writes d into working-result slice idx, sets borrow=bo and increments idx. After the edge that processes idx=NSLICE-1, the block moves to DONE.
  - DONE: one cycle with done=1 and ready=0. The next edge returns to IDLE.
- Output update:
  - diff, b_out, ovf and zero load from the working state on the edge that enters DONE.
  - They hold unchanged until the next DONE entry or reset. They are valid whenever done=1 and remain stable afterwards.
- Flag definitions:
  - b_out = final borrow.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the latched a and b.
  - b_in does not enter the ovf equation beyond its effect on diff.
  - zero = ~|diff.
- Latency: with start=1 in cycle 0 (IDLE), RUN occupies cycles 1..NSLICE and done=1 in cycle NSLICE+1 (cycle 5 at default). Earliest next accept is cycle NSLICE+2. Throughput is one operation per NSLICE+2 cycles.
- start while RUN or DONE is ignored. It is not queued, and the in-flight operands are unaffected.
- Changes on a, b or b_in after the accepting edge have no effect.
- Arithmetic is modulo 2^WIDTH. diff equals (a - b - b_in) mod 2^WIDTH for all inputs, including a=b with b_in=1, which gives all-ones with b_out=1.
- done is never high in two consecutive cycles. ready and done are never both 1.

Test Plan:
- Basic: a=0x00000005, b=0x00000003, b_in=0, start in cycle 0 -> done=1 exactly in cycle 5; diff=0x00000002, b_out=0, ovf=0, zero=0; ready=1 in cycle 6.
- Cross-slice borrow and underflow:
  - a=0x00000100, b=0x00000001 -> diff=0x000000FF, b_out=0.
  - a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, b_out=1, ovf=0.
- Signed overflow and borrow-in:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, b_out=0.
  - a=0x12345678, b=0x12345677, b_in=1 -> diff=0x00000000, zero=1, b_out=0, ovf=0.
- Handshake:
  - start held high continuously with a=10, b=4 -> results 6 at cycles 5, 11, 17, ... (one per 6 cycles).
  - Operands changed during RUN and a second start during RUN are both ignored.
  - Outputs hold between done pulses.
- Reset mid-operation: start a=0xFFFFFFFF, b=0x1, then rst=1 in cycle 2 -> the next cycle shows ready=1, done=0 and all outputs 0; no done pulse follows. A fresh start then completes normally with diff=0xFFFFFFFE.
- Random: 1000 random a, b and b_in, checked against a 33-bit reference model for diff, b_out, ovf and zero, with done latency of 5 checked on every operation.

Source files
------------

// File: rtl/seq_sub_32_bits.sv
// seq_sub_32_bits
// Multi-cycle WIDTH-bit subtractor with borrow-in. It computes a - b - b_in
// one SLICE-bit slice per clock, starting with the least-significant slice,
// and chains the borrow from each slice into the next.
//
// Handshake:
//   - An operation is accepted on a rising edge where start=1 and ready=1.
//   - done pulses for one cycle when the result is available.
//   - diff, b_out, ovf and zero then hold their values until the next
//     completion or the next reset.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, accepted only while ready=1
//   a      in   minuend, sampled on the accepting edge
//   b      in   subtrahend, sampled on the accepting edge
//   b_in   in   borrow in, sampled on the accepting edge
//   ready  out  1 only while idle
//   done   out  one-cycle completion pulse
//   diff   out  (a - b - b_in) mod 2^WIDTH
//   b_out  out  final borrow (unsigned a < b + b_in)
//   ovf    out  two's-complement overflow
//   zero   out  diff == 0
module seq_sub_32_bits #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  // Keep the slice index at least one bit wide, so that a single-slice
  // configuration still elaborates.
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE:0]   slice_res;

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slice subtractor plus working-register updates.
  // The subtraction is done one bit wider than a slice. The extra MSB is
  // the borrow out of the slice.
  // The published outputs are computed from the merged result, which
  // includes the final slice, so that they are loaded on the same edge
  // that enters DONE.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    slice_a   = a_q[int'(idx_q) * SLICE +: SLICE];
    slice_b   = b_q[int'(idx_q) * SLICE +: SLICE];
    slice_res = {1'b0, slice_a} - {1'b0, slice_b} - {{SLICE{1'b0}}, borrow_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = b_in;
          idx_d    = '0;
          res_d    = '0;
        end
      end
      RUN: begin
        res_d[int'(idx_q) * SLICE +: SLICE] = slice_res[SLICE-1:0];
        borrow_d = slice_res[SLICE];
        idx_d    = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          diff_d  = res_d;
          b_out_d = slice_res[SLICE];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = ~|res_d;
        end
      end
      default: ;
    endcase
  end

  // Output decode.
  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
    diff  = diff_q;
    b_out = b_out_q;
    ovf   = ovf_q;
    zero  = zero_q;
  end

endmodule
